// File: rtl/vga_timing_pkg.sv
// Shared timing defaults (640x480@60), RGB565 bar colours and FSM encoding for the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 40;
    localparam int DEF_H_LEFT   = 8;
    localparam int DEF_H_VALID  = 640;
    localparam int DEF_H_RIGHT  = 8;
    localparam int DEF_H_FRONT  = 8;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 25;
    localparam int DEF_V_TOP    = 8;
    localparam int DEF_V_VALID  = 480;
    localparam int DEF_V_BOTTOM = 8;
    localparam int DEF_V_FRONT  = 2;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } vga_state_t;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = RGB_WHITE;
            3'd1:    bar_color = RGB_YELLOW;
            3'd2:    bar_color = RGB_CYAN;
            3'd3:    bar_color = RGB_GREEN;
            3'd4:    bar_color = RGB_MAGENTA;
            3'd5:    bar_color = RGB_RED;
            3'd6:    bar_color = RGB_BLUE;
            default: bar_color = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Eight vertical colour bars; colour is registered on each pix_req so it lines up with pix_data.
module vga_test_pattern
    import vga_timing_pkg::*;
#(
    parameter int H_VALID = DEF_H_VALID,
    parameter int CNT_W   = 11
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    input  logic             pix_req,
    input  logic [CNT_W-1:0] pix_x,
    output logic [15:0]      pat_rgb
);

    localparam int               BAR_W    = H_VALID / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] bar_cnt;
    logic [CNT_W-1:0] cur_cnt;
    logic [2:0]       bar_idx;
    logic [2:0]       cur_idx;

    // First pixel of a line restarts the bar walk, so no line-end bookkeeping is needed.
    always_comb begin
        cur_cnt = bar_cnt;
        cur_idx = bar_idx;
        if (pix_x == '0) begin
            cur_cnt = BAR_LAST;
            cur_idx = 3'd0;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bar_cnt <= BAR_LAST;
            bar_idx <= 3'd0;
            pat_rgb <= '0;
        end else if (pix_req) begin
            pat_rgb <= bar_color(cur_idx);
            if (cur_cnt == '0) begin
                bar_cnt <= BAR_LAST;
                bar_idx <= cur_idx + 3'd1;
            end else begin
                bar_cnt <= cur_cnt - 1'b1;
                bar_idx <= cur_idx;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with frame-aligned run/stop and a 3-stage output pipeline.
// Define VGA_TEST_PATTERN_EN to add the test_en port and colour-bar generator.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_LEFT   = DEF_H_LEFT,
    parameter int H_VALID  = DEF_H_VALID,
    parameter int H_RIGHT  = DEF_H_RIGHT,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_TOP    = DEF_V_TOP,
    parameter int V_VALID  = DEF_V_VALID,
    parameter int V_BOTTOM = DEF_V_BOTTOM,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int DATA_W   = 16,
    parameter int CNT_W    = 11,
    parameter int SYNC_POL = 1,
    parameter logic [DATA_W-1:0] BORDER_COLOR = '0
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              run,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_en,
`endif
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_req,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [DATA_W-1:0] rgb,
    output logic              line_start,
    output logic              frame_start,
    output logic              busy
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
    localparam int HA = H_SYNC + H_BACK + H_LEFT;
    localparam int VA = V_SYNC + V_BACK + V_TOP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_HA     = CNT_W'(HA);
    localparam logic [CNT_W-1:0] C_HA_END = CNT_W'(HA + H_VALID);
    localparam logic [CNT_W-1:0] C_VA     = CNT_W'(VA);
    localparam logic [CNT_W-1:0] C_VA_END = CNT_W'(VA + V_VALID);
    localparam logic [CNT_W-1:0] C_HB     = CNT_W'(HA - H_LEFT);
    localparam logic [CNT_W-1:0] C_HB_END = CNT_W'(HA + H_VALID + H_RIGHT);
    localparam logic [CNT_W-1:0] C_VB     = CNT_W'(VA - V_TOP);
    localparam logic [CNT_W-1:0] C_VB_END = CNT_W'(VA + V_VALID + V_BOTTOM);
    localparam logic [CNT_W-1:0] C_HSYNC  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] C_VSYNC  = CNT_W'(V_SYNC);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);

    vga_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt_h, cnt_v;
    logic             live, frame_end, act_nxt, brd_nxt;
    logic             s1_hs, s1_vs, s1_brd, s1_ls, s1_fs;
    logic             s2_hs, s2_vs, s2_de, s2_brd, s2_ls, s2_fs;
    logic [DATA_W-1:0] act_rgb;

    assign live      = (state != ST_IDLE);
    assign busy      = live;
    assign frame_end = (cnt_h == H_LAST) && (cnt_v == V_LAST);

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (run) state_nxt = ST_RUN;
            ST_RUN:      if (!run) state_nxt = ST_STOPPING;
            ST_STOPPING: begin
                if (run)            state_nxt = ST_RUN;
                else if (frame_end) state_nxt = ST_IDLE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst || state == ST_IDLE) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    assign act_nxt = live && (cnt_h >= C_HA) && (cnt_h < C_HA_END)
                          && (cnt_v >= C_VA) && (cnt_v < C_VA_END);
    assign brd_nxt = live && (cnt_h >= C_HB) && (cnt_h < C_HB_END)
                          && (cnt_v >= C_VB) && (cnt_v < C_VB_END);

    // Stage 1: request + coordinates; stage 2 waits for pix_data; stage 3 drives the pins.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_req <= 1'b0;
            pix_x   <= '1;
            pix_y   <= '1;
            {s1_hs, s1_vs, s1_brd, s1_ls, s1_fs}        <= '0;
            {s2_hs, s2_vs, s2_de, s2_brd, s2_ls, s2_fs} <= '0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            rgb         <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_req <= act_nxt;
            pix_x   <= act_nxt ? cnt_h - C_HA : '1;
            pix_y   <= act_nxt ? cnt_v - C_VA : '1;
            s1_hs   <= live && (cnt_h < C_HSYNC);
            s1_vs   <= live && (cnt_v < C_VSYNC);
            s1_brd  <= brd_nxt;
            s1_ls   <= live && (cnt_h == '0);
            s1_fs   <= live && (cnt_h == '0) && (cnt_v == '0);

            {s2_hs, s2_vs, s2_de, s2_brd, s2_ls, s2_fs} <=
                {s1_hs, s1_vs, pix_req, s1_brd, s1_ls, s1_fs};

            hsync       <= s2_hs ? SYNC_ON : ~SYNC_ON;
            vsync       <= s2_vs ? SYNC_ON : ~SYNC_ON;
            de          <= s2_de;
            line_start  <= s2_ls;
            frame_start <= s2_fs;
            if (s2_de)       rgb <= act_rgb;
            else if (s2_brd) rgb <= BORDER_COLOR;
            else             rgb <= '0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [15:0] pat_rgb;

    vga_test_pattern #(
        .H_VALID (H_VALID),
        .CNT_W   (CNT_W)
    ) u_test_pattern (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .pix_req (pix_req),
        .pix_x   (pix_x),
        .pat_rgb (pat_rgb)
    );

    assign act_rgb = test_en ? pat_rgb : pix_data;
`else
    assign act_rgb = pix_data;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced timing so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int HS = 3, HB = 2, HL = 1, HV = 16, HR = 1, HF = 2;
    localparam int VS = 2, VB = 2, VT = 1, VV = 8, VBM = 1, VF = 2;
    localparam int HT  = HS + HB + HL + HV + HR + HF;
    localparam int VTT = VS + VB + VT + VV + VBM + VF;
    localparam int TOT = HT * VTT;
    localparam int HA  = HS + HB + HL;
    localparam int VA  = VS + VB + VT;
    localparam int POL = 0;
    localparam logic [15:0] BORDER = 16'hA5C3;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] pix_data = '0;
    logic        test_en = 1'b0;
    logic        pix_req, hsync, vsync, de, line_start, frame_start, busy;
    logic [10:0] pix_x, pix_y;
    logic [15:0] rgb;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_LEFT(HL), .H_VALID(HV), .H_RIGHT(HR), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_TOP(VT), .V_VALID(VV), .V_BOTTOM(VBM), .V_FRONT(VF),
        .DATA_W(16), .CNT_W(11), .SYNC_POL(POL), .BORDER_COLOR(BORDER)
    ) dut (
        .vga_clk     (vga_clk),
        .sys_rst     (sys_rst),
        .run         (run),
`ifdef VGA_TEST_PATTERN_EN
        .test_en     (test_en),
`endif
        .pix_data    (pix_data),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .line_start  (line_start),
        .frame_start (frame_start),
        .busy        (busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference: mode 0 idle / 1 running / 2 finishing frame; pos is the linear raster index.
    int m_mode, m_pos;
    int h_live[$];
    int h_pos[$];
    logic [15:0] d_now;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    function automatic bit is_act(int p);
        int h = p % HT;
        int v = p / HT;
        return (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
    endfunction

    function automatic bit is_brd(int p);
        int h = p % HT;
        int v = p / HT;
        return (h >= HA - HL) && (h < HA + HV + HR) && (v >= VA - VT) && (v < VA + VV + VBM);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pos  = 0;
        h_live = '{0, 0, 0, 0};
        h_pos  = '{0, 0, 0, 0};
    endtask

    task automatic model_step(logic r);
        int old = m_pos;
        case (m_mode)
            0: begin if (r) m_mode = 1; m_pos = 0; end
            1: begin m_pos = (old + 1) % TOT; if (!r) m_mode = 2; end
            default: begin
                m_pos = (old + 1) % TOT;
                if (r) m_mode = 1;
                else if (old == TOT - 1) m_mode = 0;
            end
        endcase
        h_live.push_front(m_mode != 0);
        h_pos.push_front(m_pos);
        void'(h_live.pop_back());
        void'(h_pos.pop_back());
    endtask

    task automatic check_outputs();
        bit a1, l3, d3;
        int p1, p3;
        logic [15:0] exp_rgb;
        p1 = h_pos[1];
        a1 = (h_live[1] != 0) && is_act(p1);
        p3 = h_pos[3];
        l3 = (h_live[3] != 0);
        d3 = l3 && is_act(p3);
        if (d3) exp_rgb = test_en ? bars[(p3 % HT - HA) / (HV / 8)] : d_now;
        else if (l3 && is_brd(p3)) exp_rgb = BORDER;
        else exp_rgb = 16'h0;
        chk("pix_req", 32'(pix_req), 32'(a1));
        chk("pix_x", 32'(pix_x), a1 ? 32'(p1 % HT - HA) : 32'h7FF);
        chk("pix_y", 32'(pix_y), a1 ? 32'(p1 / HT - VA) : 32'h7FF);
        chk("hsync", 32'(hsync), (l3 && (p3 % HT < HS)) ? 32'(POL) : 32'(1 - POL));
        chk("vsync", 32'(vsync), (l3 && (p3 / HT < VS)) ? 32'(POL) : 32'(1 - POL));
        chk("de", 32'(de), 32'(d3));
        chk("rgb", 32'(rgb), 32'(exp_rgb));
        chk("line_start", 32'(line_start), 32'(l3 && (p3 % HT == 0)));
        chk("frame_start", 32'(frame_start), 32'(l3 && (p3 == 0)));
        chk("busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic tick();
        logic r;
        r = run;
        d_now = pix_data;
        @(posedge vga_clk);
        model_step(r);
        @(negedge vga_clk);
        check_outputs();
        pix_data = 16'($urandom);
    endtask

    initial begin
        int n, p0, de_n, hs_n, vs_n, ls_n;
        model_reset();
        repeat (3) @(negedge vga_clk);
        check_outputs();
        sys_rst = 1'b0;
        repeat (5) tick();

        // Start, then measure one full frame between frame_start strobes.
        run = 1'b1;
        for (n = 0; n < 2 * TOT; n++) begin
            tick();
            if (frame_start) break;
        end
        chk("first_frame_start", 32'(frame_start), 32'd1);
        chk("first_fs_latency", 32'(n), 32'd3);
        de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0;
        for (int i = 0; i < TOT; i++) begin
            if (i > 0) tick();
            de_n += int'(de);
            hs_n += int'(hsync == 1'(POL));
            vs_n += int'(vsync == 1'(POL));
            ls_n += int'(line_start);
        end
        tick();
        chk("frame_period", 32'(frame_start), 32'd1);
        chk("de_count", 32'(de_n), 32'(HV * VV));
        chk("hsync_count", 32'(hs_n), 32'(HS * VTT));
        chk("vsync_count", 32'(vs_n), 32'(VS * HT));
        chk("line_count", 32'(ls_n), 32'(VTT));

        // Stop mid-frame: must run to end of frame and then go idle.
        for (int i = 0; i < 2 * TOT && !(m_mode == 1 && m_pos / HT == 3); i++) tick();
        p0 = m_pos;
        run = 1'b0;
        for (n = 0; n < 3 * TOT && busy; n++) tick();
        chk("stop_len", 32'(n), 32'(TOT - p0));
        repeat (6) tick();

        // Stop requested then withdrawn: raster continues without a break.
        run = 1'b1;
        for (int i = 0; i < 3 * TOT && !(m_mode == 1 && m_pos / HT == 3); i++) tick();
        run = 1'b0;
        for (int i = 0; i < 3 * TOT && !(m_pos / HT == 6); i++) tick();
        run = 1'b1;
        repeat (2 * TOT) tick();

        // Random run toggling and random pixel data.
        for (int s = 0; s < 30; s++) begin
            run = 1'($urandom_range(0, 1));
`ifdef VGA_TEST_PATTERN_EN
            test_en = 1'($urandom_range(0, 1));
`endif
            n = $urandom_range(1, 2 * TOT);
            repeat (n) tick();
        end
        test_en = 1'b0;

        // Asynchronous reset in the middle of a line.
        run = 1'b1;
        for (int i = 0; i < 3 * TOT && !(m_mode == 1 && m_pos == 2 * HT + 10); i++) tick();
        #2 sys_rst = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge vga_clk);
        @(negedge vga_clk);
        sys_rst = 1'b0;
        for (n = 1; n <= 10; n++) begin
            tick();
            if (frame_start) break;
        end
        chk("restart_fs_latency", 32'(n), 32'd4);
        repeat (TOT + 20) tick();

        run = 1'b0;
        for (int i = 0; i < 3 * TOT && busy; i++) tick();
        chk("final_idle", 32'(busy), 32'd0);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
